// File: rtl/dmem_rr_arbiter_pkg.sv
// Shared constants and types for the data-memory round-robin arbiter.
// The SC response encoding and access-op classification live here.
package dmem_rr_arbiter_pkg;

  localparam int unsigned DmemAddrw = 12;
  localparam int unsigned NCores    = 4;

  // SC.W result word (bit 0)
  localparam logic ScOk   = 1'b0;
  localparam logic ScFail = 1'b1;

  typedef enum logic [1:0] {
    OpNone,
    OpRead,
    OpWrite,
    OpScFail
  } op_e;

  // Index width that stays legal for a single hart.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? unsigned'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/dmem_rr_arbiter_if.sv
// Hart-side and BRAM-side bus of the data-memory arbiter.
// Per-hart fields are flat vectors, hart k occupying slice k.
interface dmem_rr_arbiter_if #(
  parameter int unsigned NCORES = dmem_rr_arbiter_pkg::NCores,
  parameter int unsigned ADDRW  = dmem_rr_arbiter_pkg::DmemAddrw
);
  import dmem_rr_arbiter_pkg::*;

  logic [NCORES-1:0]       re_i;
  logic [NCORES-1:0]       we_i;
  logic [ADDRW*NCORES-1:0] addr_i;
  logic [32*NCORES-1:0]    wdata_i;
  logic [4*NCORES-1:0]     wstrb_i;
  logic [NCORES-1:0]       is_lr_i;
  logic [NCORES-1:0]       is_sc_i;
  logic [32*NCORES-1:0]    rdata_o;
  logic [NCORES-1:0]       stall_o;

  logic                    mem_en_o;
  logic [3:0]              mem_we_o;
  logic [ADDRW-1:0]        mem_addr_o;
  logic [31:0]             mem_wdata_o;
  logic [31:0]             mem_rdata_i;

  // Arbiter side
  modport slave (
    input  re_i, we_i, addr_i, wdata_i, wstrb_i, is_lr_i, is_sc_i, mem_rdata_i,
    output rdata_o, stall_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  // Harts plus BRAM side
  modport master (
    output re_i, we_i, addr_i, wdata_i, wstrb_i, is_lr_i, is_sc_i, mem_rdata_i,
    input  rdata_o, stall_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

endinterface

// File: rtl/dmem_rr_arbiter_rr_grant.sv
// Combinational round-robin picker: searches req starting at last+1 and
// returns a one-hot grant plus its encoded index.
module dmem_rr_arbiter_rr_grant #(
  parameter int unsigned NCORES = 4,
  parameter int unsigned IdxW   = 2
) (
  input  logic [NCORES-1:0] req,
  input  logic [IdxW-1:0]   last,
  output logic [NCORES-1:0] grant,
  output logic [IdxW-1:0]   idx
);
  import dmem_rr_arbiter_pkg::*;

  logic        found;
  int unsigned pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int unsigned i = 1; i <= NCORES; i++) begin
      pos = (32'(last) + i) % NCORES;
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = IdxW'(pos);
      end
    end
  end

endmodule

// File: rtl/dmem_rr_arbiter.sv
// Shares the single-port data BRAM among NCORES harts, one grant per cycle,
// and keeps per-hart LR/SC reservations snooped by every performed write.
module dmem_rr_arbiter #(
  parameter int unsigned NCORES = dmem_rr_arbiter_pkg::NCores,
  parameter int unsigned ADDRW  = dmem_rr_arbiter_pkg::DmemAddrw
) (
  input logic              clk_i,
  input logic              rst_ni,
  dmem_rr_arbiter_if.slave bus
);
  import dmem_rr_arbiter_pkg::*;

  localparam int unsigned IdxW = idx_width(NCORES);

  logic [NCORES-1:0]            req;
  logic [NCORES-1:0]            grant_raw;
  logic [NCORES-1:0]            grant;
  logic                         any_grant;
  logic [IdxW-1:0]              gidx;

  logic [ADDRW-1:0]             g_addr;
  logic [31:0]                  g_wdata;
  logic [3:0]                   g_wstrb;
  logic                         g_we;
  logic                         g_lr;
  logic                         g_sc;
  logic                         sc_ok;
  op_e                          op;

  logic [IdxW-1:0]              last_q, last_d;
  logic [NCORES-1:0]            resv_v_q, resv_v_d;
  logic [NCORES-1:0][ADDRW-1:0] resv_a_q, resv_a_d;
  logic                         resp_v_q, resp_v_d;
  logic [IdxW-1:0]              resp_id_q, resp_id_d;
  logic                         resp_sc_q, resp_sc_d;
  logic                         resp_fail_q, resp_fail_d;
  logic [NCORES-1:0][31:0]      hold_q, hold_d;
  logic [31:0]                  resp_data;
  logic [NCORES-1:0][31:0]      rdata;

  assign req = bus.re_i | bus.we_i;

  dmem_rr_arbiter_rr_grant #(
    .NCORES(NCORES),
    .IdxW  (IdxW)
  ) u_rr_grant (
    .req  (req),
    .last (last_q),
    .grant(grant_raw),
    .idx  (gidx)
  );

  // No grants while reset is asserted, so every requester sees a stall.
  assign grant     = rst_ni ? grant_raw : '0;
  assign any_grant = |grant;
  assign bus.stall_o = req & ~grant;

  // Decode the granted hart's request
  always_comb begin
    g_addr  = bus.addr_i[int'(gidx)*ADDRW +: ADDRW];
    g_wdata = bus.wdata_i[int'(gidx)*32 +: 32];
    g_wstrb = bus.wstrb_i[int'(gidx)*4 +: 4];
    g_we    = bus.we_i[gidx];
    g_lr    = bus.is_lr_i[gidx] & ~g_we;
    g_sc    = bus.is_sc_i[gidx] & g_we;
    sc_ok   = resv_v_q[gidx] & (resv_a_q[gidx] == g_addr);
    if (!any_grant) begin
      op = OpNone;
    end else if (g_sc && !sc_ok) begin
      op = OpScFail;
    end else if (g_we) begin
      op = OpWrite;
    end else begin
      op = OpRead;
    end
  end

  assign bus.mem_en_o    = (op == OpRead) || (op == OpWrite);
  assign bus.mem_we_o    = (op == OpWrite) ? g_wstrb : 4'b0000;
  assign bus.mem_addr_o  = g_addr;
  assign bus.mem_wdata_o = g_wdata;

  // Reservation table update
  always_comb begin
    resv_v_d = resv_v_q;
    resv_a_d = resv_a_q;
    if (op == OpWrite) begin
      // A performed write kills other harts' reservations on the same word.
      for (int unsigned j = 0; j < NCORES; j++) begin
        if ((IdxW'(j) != gidx) && (resv_a_q[j] == g_addr)) begin
          resv_v_d[j] = 1'b0;
        end
      end
    end
    if ((op == OpRead) && g_lr) begin
      resv_v_d[gidx] = 1'b1;
      resv_a_d[gidx] = g_addr;
    end
    if (any_grant && g_sc) begin
      resv_v_d[gidx] = 1'b0;
    end
  end

  always_comb begin
    last_d      = any_grant ? gidx : last_q;
    resp_v_d    = any_grant;
    resp_id_d   = gidx;
    resp_sc_d   = any_grant & g_sc;
    resp_fail_d = (op == OpScFail);
  end

  // Response path, one cycle after grant
  always_comb begin
    resp_data = resp_sc_q ? {31'b0, (resp_fail_q ? ScFail : ScOk)} : bus.mem_rdata_i;
    hold_d    = hold_q;
    if (resp_v_q) begin
      hold_d[resp_id_q] = resp_data;
    end
    for (int unsigned k = 0; k < NCORES; k++) begin
      rdata[k] = (resp_v_q && (resp_id_q == IdxW'(k))) ? resp_data : hold_q[k];
    end
  end

  assign bus.rdata_o = rdata;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q      <= IdxW'(NCORES - 1);
      resv_v_q    <= '0;
      resv_a_q    <= '0;
      resp_v_q    <= 1'b0;
      resp_id_q   <= '0;
      resp_sc_q   <= 1'b0;
      resp_fail_q <= 1'b0;
      hold_q      <= '0;
    end else begin
      last_q      <= last_d;
      resv_v_q    <= resv_v_d;
      resv_a_q    <= resv_a_d;
      resp_v_q    <= resp_v_d;
      resp_id_q   <= resp_id_d;
      resp_sc_q   <= resp_sc_d;
      resp_fail_q <= resp_fail_d;
      hold_q      <= hold_d;
    end
  end

endmodule
